systolic_tile_scheduler: RTL and testbench

//  Tiling controller for the TxT systolic-array wrapper. Launches on a start pulse from the SP BRAM.

---
 rtl/systolic_tile_scheduler.sv | 241 ++++++++++++++++++++++++
 tb/tb_systolic_tile_scheduler.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_scheduler.sv
// Tiling controller for a TILE x TILE systolic array.
// Walks an M x K x N GEMM in TILE-sized blocks (WS or OS loop order) and
// issues one tile command at a time: A/W/O base addresses, edge sizes and
// first/last-k flags. Edge tiles carry their true sizes, so the host does
// not need to zero-pad the operands.
module systolic_tile_scheduler #(
    parameter int TILE   = 8,
    parameter int DIM_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DIM_W-1:0]  m_dim,
    input  logic [DIM_W-1:0]  k_dim,
    input  logic [DIM_W-1:0]  n_dim,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_a_base,
    output logic [ADDR_W-1:0] cmd_w_base,
    output logic [ADDR_W-1:0] cmd_o_base,
    output logic [DIM_W-1:0]  cmd_rows,
    output logic [DIM_W-1:0]  cmd_cols,
    output logic [DIM_W-1:0]  cmd_depth,
    output logic              cmd_first,
    output logic              cmd_last,
    input  logic              tile_done,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [DIM_W-1:0]  TILE_D     = DIM_W'(TILE);
    localparam logic [ADDR_W-1:0] TILE_BYTES = ADDR_W'(TILE * 4);

    state_t state_reg, state_next;

    // start_low_reg remembers that start was seen low on the previous cycle.
    // It clears on reset, so a start level still high after reset cannot launch.
    logic              start_low_reg;
    logic              mode_reg;
    logic              cfg_err_reg;
    logic [DIM_W-1:0]  m_reg, k_reg, n_reg;
    // Remaining extent from the current tile origin to the matrix edge.
    logic [DIM_W-1:0]  rem_m_reg, rem_k_reg, rem_n_reg;
    logic [DIM_W-1:0]  kt_reg, nt_reg;
    // Byte offsets of the current tile row: mt*TILE*k*4, kt*TILE*n*4, mt*TILE*n*4.
    logic [ADDR_W-1:0] a_row_reg, w_row_reg, o_row_reg;

    logic launch, dims_zero;
    logic last_m, last_k, last_n;
    logic step_m, step_k, step_n;
    logic wrap_m, wrap_k, wrap_n;
    logic issue;
    logic [ADDR_W-1:0] a_row_step, w_row_step, o_row_step;

    assign launch    = (state_reg == S_IDLE) && start && start_low_reg;
    assign dims_zero = (m_dim == '0) || (k_dim == '0) || (n_dim == '0);
    assign last_m    = (rem_m_reg <= TILE_D);
    assign last_k    = (rem_k_reg <= TILE_D);
    assign last_n    = (rem_n_reg <= TILE_D);

    // Advancing one tile row in A/O moves TILE*k or TILE*n elements.
    assign a_row_step = ADDR_W'(k_reg) * TILE_BYTES;
    assign w_row_step = ADDR_W'(n_reg) * TILE_BYTES;
    assign o_row_step = ADDR_W'(n_reg) * TILE_BYTES;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus tile-counter step/wrap controls for the selected loop order.
    always_comb begin
        state_next = state_reg;
        step_m = 1'b0;
        step_k = 1'b0;
        step_n = 1'b0;
        wrap_m = 1'b0;
        wrap_k = 1'b0;
        wrap_n = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (launch) begin
                    state_next = dims_zero ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tile_done) begin
                    state_next = S_ISSUE;
                    if (mode_reg) begin
                        // OS: kt innermost, then nt, then mt.
                        if (!last_k) begin
                            step_k = 1'b1;
                        end else begin
                            wrap_k = 1'b1;
                            if (!last_n) begin
                                step_n = 1'b1;
                            end else begin
                                wrap_n = 1'b1;
                                if (!last_m) begin
                                    step_m = 1'b1;
                                end else begin
                                    state_next = S_DONE;
                                end
                            end
                        end
                    end else begin
                        // WS: mt innermost so the W tile is reused, then kt, then nt.
                        if (!last_m) begin
                            step_m = 1'b1;
                        end else begin
                            wrap_m = 1'b1;
                            if (!last_k) begin
                                step_k = 1'b1;
                            end else begin
                                wrap_k = 1'b1;
                                if (!last_n) begin
                                    step_n = 1'b1;
                                end else begin
                                    state_next = S_DONE;
                                end
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Start-edge tracking, job configuration latch and the error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_low_reg <= 1'b0;
            mode_reg      <= 1'b0;
            m_reg         <= '0;
            k_reg         <= '0;
            n_reg         <= '0;
            cfg_err_reg   <= 1'b0;
        end else begin
            start_low_reg <= !start;
            if (launch) begin
                mode_reg    <= mode;
                m_reg       <= m_dim;
                k_reg       <= k_dim;
                n_reg       <= n_dim;
                cfg_err_reg <= dims_zero;
            end else if (state_reg == S_DONE && !start) begin
                cfg_err_reg <= 1'b0;
            end
        end
    end

    // Tile position tracked incrementally: remaining extents and row offsets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_m_reg <= '0;
            rem_k_reg <= '0;
            rem_n_reg <= '0;
            kt_reg    <= '0;
            nt_reg    <= '0;
            a_row_reg <= '0;
            w_row_reg <= '0;
            o_row_reg <= '0;
        end else if (launch) begin
            rem_m_reg <= m_dim;
            rem_k_reg <= k_dim;
            rem_n_reg <= n_dim;
            kt_reg    <= '0;
            nt_reg    <= '0;
            a_row_reg <= '0;
            w_row_reg <= '0;
            o_row_reg <= '0;
        end else begin
            if (step_m) begin
                rem_m_reg <= rem_m_reg - TILE_D;
                a_row_reg <= a_row_reg + a_row_step;
                o_row_reg <= o_row_reg + o_row_step;
            end else if (wrap_m) begin
                rem_m_reg <= m_reg;
                a_row_reg <= '0;
                o_row_reg <= '0;
            end
            if (step_k) begin
                rem_k_reg <= rem_k_reg - TILE_D;
                kt_reg    <= kt_reg + 1'b1;
                w_row_reg <= w_row_reg + w_row_step;
            end else if (wrap_k) begin
                rem_k_reg <= k_reg;
                kt_reg    <= '0;
                w_row_reg <= '0;
            end
            if (step_n) begin
                rem_n_reg <= rem_n_reg - TILE_D;
                nt_reg    <= nt_reg + 1'b1;
            end else if (wrap_n) begin
                rem_n_reg <= n_reg;
                nt_reg    <= '0;
            end
        end
    end

    // Command fields are driven only while a command is offered, zero otherwise.
    assign issue      = (state_reg == S_ISSUE);
    assign cmd_valid  = issue;
    assign cmd_a_base = issue ? (a_row_reg + ADDR_W'(kt_reg) * TILE_BYTES) : '0;
    assign cmd_w_base = issue ? (w_row_reg + ADDR_W'(nt_reg) * TILE_BYTES) : '0;
    assign cmd_o_base = issue ? (o_row_reg + ADDR_W'(nt_reg) * TILE_BYTES) : '0;
    assign cmd_rows   = issue ? (last_m ? rem_m_reg : TILE_D) : '0;
    assign cmd_cols   = issue ? (last_n ? rem_n_reg : TILE_D) : '0;
    assign cmd_depth  = issue ? (last_k ? rem_k_reg : TILE_D) : '0;
    assign cmd_first  = issue && (kt_reg == '0);
    assign cmd_last   = issue && last_k;
    assign busy       = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
    assign done       = (state_reg == S_DONE);
    assign cfg_err    = cfg_err_reg;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Bench for systolic_tile_scheduler: directed scenarios plus randomized jobs
// checked against a loop-nest reference model of the tiling order.
module tb_systolic_tile_scheduler;

    localparam int TILE   = 8;
    localparam int DIM_W  = 16;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic              start;
    logic              mode;
    logic [DIM_W-1:0]  m_dim, k_dim, n_dim;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_a_base, cmd_w_base, cmd_o_base;
    logic [DIM_W-1:0]  cmd_rows, cmd_cols, cmd_depth;
    logic              cmd_first, cmd_last;
    logic              tile_done;
    logic              busy, done, cfg_err;

    systolic_tile_scheduler #(.TILE(TILE), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .m_dim(m_dim), .k_dim(k_dim), .n_dim(n_dim),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a_base(cmd_a_base), .cmd_w_base(cmd_w_base), .cmd_o_base(cmd_o_base),
        .cmd_rows(cmd_rows), .cmd_cols(cmd_cols), .cmd_depth(cmd_depth),
        .cmd_first(cmd_first), .cmd_last(cmd_last), .tile_done(tile_done),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] o;
        logic [15:0] rows;
        logic [15:0] cols;
        logic [15:0] depth;
        logic        first;
        logic        last;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t obs_q[$];
    int   checks = 0;
    int   errors = 0;
    int   proto_bad;
    bit   done_seen, cfg_seen, done_cleared;

    function automatic cmd_t cur_cmd();
        cmd_t c;
        c.a = cmd_a_base; c.w = cmd_w_base; c.o = cmd_o_base;
        c.rows = cmd_rows; c.cols = cmd_cols; c.depth = cmd_depth;
        c.first = cmd_first; c.last = cmd_last;
        return c;
    endfunction

    function automatic int min_i(int x, int y);
        return (x < y) ? x : y;
    endfunction

    function automatic cmd_t make_cmd(int mt, int kt, int nt, int m, int k, int n);
        cmd_t c;
        int kcount;
        kcount  = (k + TILE - 1) / TILE;
        c.a     = 32'((longint'(mt) * TILE * k + kt * TILE) * 4);
        c.w     = 32'((longint'(kt) * TILE * n + nt * TILE) * 4);
        c.o     = 32'((longint'(mt) * TILE * n + nt * TILE) * 4);
        c.rows  = 16'(min_i(TILE, m - mt * TILE));
        c.cols  = 16'(min_i(TILE, n - nt * TILE));
        c.depth = 16'(min_i(TILE, k - kt * TILE));
        c.first = (kt == 0);
        c.last  = (kt == kcount - 1);
        return c;
    endfunction

    // Reference command list: plain nested loops in the documented order.
    function automatic void build_expected(bit md, int m, int k, int n);
        int mc, kc, nc;
        exp_q.delete();
        mc = (m + TILE - 1) / TILE;
        kc = (k + TILE - 1) / TILE;
        nc = (n + TILE - 1) / TILE;
        if (md) begin
            for (int mt = 0; mt < mc; mt++)
                for (int nt = 0; nt < nc; nt++)
                    for (int kt = 0; kt < kc; kt++)
                        exp_q.push_back(make_cmd(mt, kt, nt, m, k, n));
        end else begin
            for (int nt = 0; nt < nc; nt++)
                for (int kt = 0; kt < kc; kt++)
                    for (int mt = 0; mt < mc; mt++)
                        exp_q.push_back(make_cmd(mt, kt, nt, m, k, n));
        end
    endfunction

    // Runs one job as the datapath would: random stalls, random tile latency,
    // optional stray tile_done pulses while a command is pending acceptance.
    task automatic drive_job(input bit md, input int m, input int k, input int n,
                             input int max_stall, input bit noise);
        cmd_t snap;
        int   stall, dly, guard;
        obs_q.delete();
        proto_bad = 0; done_seen = 0; cfg_seen = 0; done_cleared = 0;
        start = 1'b0; cmd_ready = 1'b0; tile_done = 1'b0;
        @(negedge clk);
        mode = md; m_dim = 16'(m); k_dim = 16'(k); n_dim = 16'(n); start = 1'b1;
        @(negedge clk);
        mode = 1'($urandom); m_dim = 16'($urandom); k_dim = 16'($urandom); n_dim = 16'($urandom);
        guard = 0;
        while (!done) begin
            if (!cmd_valid || guard > 400) begin
                proto_bad++;
                break;
            end
            guard++;
            snap  = cur_cmd();
            stall = $urandom_range(0, max_stall);
            for (int s = 0; s < stall; s++) begin
                tile_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
                if (!cmd_valid || cur_cmd() !== snap) proto_bad++;
            end
            tile_done = 1'b0;
            cmd_ready = 1'b1;
            obs_q.push_back(cur_cmd());
            @(negedge clk);
            cmd_ready = 1'b0;
            if (cmd_valid || !busy) proto_bad++;
            dly = $urandom_range(0, 3);
            repeat (dly) @(negedge clk);
            tile_done = 1'b1;
            @(negedge clk);
            tile_done = 1'b0;
        end
        done_seen = done;
        cfg_seen  = cfg_err;
        if (busy) proto_bad++;
        start = 1'b0;
        @(negedge clk);
        done_cleared = !done && !cfg_err;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 1'b0; cmd_ready = 1'b0; tile_done = 1'b0;
        m_dim = '0; k_dim = '0; n_dim = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_valid, busy, done, cfg_err, cmd_first, cmd_last} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000",
                     {cmd_valid, busy, done, cfg_err, cmd_first, cmd_last});
        end
        checks++;
        if (cur_cmd() !== cmd_t'(0)) begin
            errors++;
            $display("FAIL reset_fields: got %h required 0", cur_cmd());
        end
        reset = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single_tile();
        cmd_t want;
        want = '{a: 32'd0, w: 32'd0, o: 32'd0, rows: 16'd8, cols: 16'd8, depth: 16'd8,
                 first: 1'b1, last: 1'b1};
        drive_job(1'b1, 8, 8, 8, 0, 1'b0);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== want) begin
            errors++;
            $display("FAIL single_cmd: got count %0d first %h required count 1 cmd %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : cmd_t'(0), want);
        end
        checks++;
        if (!done_seen || cfg_seen || proto_bad != 0 || !done_cleared) begin
            errors++;
            $display("FAIL single_done: got done=%0d cfg_err=%0d proto=%0d cleared=%0d required 1 0 0 1",
                     done_seen, cfg_seen, proto_bad, done_cleared);
        end
        $display("test_single_tile cmds=%0d", obs_q.size());
    endtask

    task automatic test_os_example();
        build_expected(1'b1, 12, 20, 4);
        drive_job(1'b1, 12, 20, 4, 2, 1'b1);
        checks++;
        if (obs_q.size() != 6) begin
            errors++;
            $display("FAIL os_count: got %0d required 6", obs_q.size());
        end
        for (int i = 0; i < min_i(obs_q.size(), exp_q.size()); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL os_cmd%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == 6) begin
            checks++;
            if (obs_q[5].a !== 32'd704 || obs_q[5].o !== 32'd128 || obs_q[5].rows !== 16'd4 ||
                obs_q[5].depth !== 16'd4 || obs_q[5].last !== 1'b1 || obs_q[5].first !== 1'b0) begin
                errors++;
                $display("FAIL os_last_tile: got a=%0d o=%0d rows=%0d depth=%0d first=%0d last=%0d required 704 128 4 4 0 1",
                         obs_q[5].a, obs_q[5].o, obs_q[5].rows, obs_q[5].depth, obs_q[5].first, obs_q[5].last);
            end
        end
        checks++;
        if (!done_seen || proto_bad != 0 || !done_cleared) begin
            errors++;
            $display("FAIL os_protocol: got done=%0d proto=%0d cleared=%0d required 1 0 1",
                     done_seen, proto_bad, done_cleared);
        end
        $display("test_os_example cmds=%0d", obs_q.size());
    endtask

    task automatic test_ws_example();
        build_expected(1'b0, 12, 20, 4);
        drive_job(1'b0, 12, 20, 4, 2, 1'b1);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ws_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < min_i(obs_q.size(), exp_q.size()); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].first !== (i < 2)) begin
                errors++;
                $display("FAIL ws_cmd%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() > 1) begin
            checks++;
            if (obs_q[1].a !== 32'd640 || obs_q[1].w !== 32'd0 || obs_q[1].o !== 32'd128) begin
                errors++;
                $display("FAIL ws_second: got a=%0d w=%0d o=%0d required 640 0 128",
                         obs_q[1].a, obs_q[1].w, obs_q[1].o);
            end
        end
        $display("test_ws_example cmds=%0d", obs_q.size());
    endtask

    task automatic test_backpressure();
        build_expected(1'b1, 12, 20, 4);
        start = 1'b0; cmd_ready = 1'b0; tile_done = 1'b0;
        @(negedge clk);
        mode = 1'b1; m_dim = 16'd12; k_dim = 16'd20; n_dim = 16'd4; start = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0; tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cur_cmd() !== exp_q[1]) begin
                errors++;
                $display("FAIL stall_cycle%0d: got valid=%0d cmd %h required valid=1 cmd %h",
                         c, cmd_valid, cur_cmd(), exp_q[1]);
            end
            @(negedge clk);
        end
        checks++;
        if (cmd_valid !== 1'b1 || cur_cmd() !== exp_q[1]) begin
            errors++;
            $display("FAIL stall_cycle6: got valid=%0d cmd %h required valid=1 cmd %h",
                     cmd_valid, cur_cmd(), exp_q[1]);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept: got valid=%0d busy=%0d required valid=0 busy=1", cmd_valid, busy);
        end
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("test_backpressure done");
    endtask

    task automatic test_cfg_err();
        for (int p = 0; p < 3; p++) begin
            start = 1'b0;
            @(negedge clk);
            mode = 1'($urandom);
            m_dim = (p == 0) ? 16'd0 : 16'd9;
            k_dim = (p == 1) ? 16'd0 : 16'd17;
            n_dim = (p == 2) ? 16'd0 : 16'd3;
            start = 1'b1;
            @(negedge clk);
            checks++;
            if ({done, cfg_err, cmd_valid, busy} !== 4'b1100) begin
                errors++;
                $display("FAIL cfg_err_flag%0d: got done,cfg_err,valid,busy=%b required 1100",
                         p, {done, cfg_err, cmd_valid, busy});
            end
            repeat (4) begin
                @(negedge clk);
                checks++;
                if (cmd_valid !== 1'b0 || done !== 1'b1) begin
                    errors++;
                    $display("FAIL cfg_err_hold%0d: got valid=%0d done=%0d required 0 1", p, cmd_valid, done);
                end
            end
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_clear%0d: got done=%0d cfg_err=%0d required 0 0", p, done, cfg_err);
            end
            $display("test_cfg_err pattern %0d", p);
        end
    endtask

    task automatic test_reset_mid_job();
        build_expected(1'b1, 12, 20, 4);
        start = 1'b0; cmd_ready = 1'b0; tile_done = 1'b0;
        @(negedge clk);
        mode = 1'b1; m_dim = 16'd12; k_dim = 16'd20; n_dim = 16'd4; start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            if (i < 2) begin
                tile_done = 1'b1;
                @(negedge clk);
                tile_done = 1'b0;
            end
        end
        checks++;
        if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL midjob_wait: got busy=%0d valid=%0d required 1 0", busy, cmd_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({cmd_valid, busy, done, cfg_err} !== 4'b0 || cur_cmd() !== cmd_t'(0)) begin
            errors++;
            $display("FAIL midjob_reset: got flags=%b cmd %h required 0000 and 0",
                     {cmd_valid, busy, done, cfg_err}, cur_cmd());
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({cmd_valid, busy, done} !== 3'b0) begin
                errors++;
                $display("FAIL midjob_norelaunch%0d: got valid,busy,done=%b required 000",
                         c, {cmd_valid, busy, done});
            end
        end
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || cur_cmd() !== exp_q[0]) begin
            errors++;
            $display("FAIL midjob_relaunch: got valid=%0d cmd %h required valid=1 cmd %h",
                     cmd_valid, cur_cmd(), exp_q[0]);
        end
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("test_reset_mid_job done");
    endtask

    task automatic test_back_to_back();
        bit md;
        int m, k, n;
        for (int j = 0; j < 20; j++) begin
            md = 1'($urandom_range(0, 1));
            m  = (j % 5 == 0) ? 8 * $urandom_range(1, 4) : $urandom_range(1, 40);
            k  = $urandom_range(1, 40);
            n  = $urandom_range(1, 40);
            build_expected(md, m, k, n);
            drive_job(md, m, k, n, 3, 1'b1);
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL job%0d_count: got %0d required %0d", j, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < min_i(obs_q.size(), exp_q.size()); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL job%0d_cmd%0d: got %h required %h", j, i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (!done_seen || cfg_seen || proto_bad != 0 || !done_cleared) begin
                errors++;
                $display("FAIL job%0d_protocol: got done=%0d cfg_err=%0d proto=%0d cleared=%0d required 1 0 0 1",
                         j, done_seen, cfg_seen, proto_bad, done_cleared);
            end
            $display("job %0d mode=%0d m=%0d k=%0d n=%0d cmds=%0d", j, md, m, k, n, obs_q.size());
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; cmd_ready = 1'b0; tile_done = 1'b0;
        m_dim = '0; k_dim = '0; n_dim = '0;
        test_reset();
        test_single_tile();
        test_os_example();
        test_ws_example();
        test_backpressure();
        test_cfg_err();
        test_reset_mid_job();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
